// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/reset/single-step sequencer for the soft CPU.
//   Each board button is synchronised and debounced. A debounced press on btn1
//   restarts the CPU through a fixed reset window. A debounced press on btn2
//   halts the CPU, or single-steps it when it is already halted. CPU progress
//   is gated with a clock enable; the CPU clock itself is never gated.
// Ports:
//   clk         system clock
//   reset       asynchronous active-low block reset
//   btn1, btn2  raw active-low buttons (btn1 = restart, btn2 = halt/step)
//   cpu_rst_n   CPU reset, active-low
//   cpu_clk_en  CPU clock enable
//   halted      high in HALT and STEP
//   state       FSM state code, for LEDs/debug
// All outputs are registered together with the state register.
module cpu_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned CNT_W           = 17,
  parameter int unsigned RESET_HOLD      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn1,
  input  logic       btn2,
  output logic       cpu_rst_n,
  output logic       cpu_clk_en,
  output logic       halted,
  output logic [2:0] state
);

  localparam int unsigned HoldW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    StInit = 3'd0,
    StHold = 3'd1,
    StRun  = 3'd2,
    StHalt = 3'd3,
    StStep = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronise and debounce; bit 0 = btn1, bit 1 = btn2
  // ---------------------------------------------------------------------------
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d, deb_prev_q;
  logic [1:0]       press_q, press_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign btn_raw = {btn2, btn1};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DebLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    // One pulse, one cycle after the debounced level falls; releases are silent.
    press_d = deb_prev_q & ~deb_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      deb_q      <= 2'b11;
      deb_prev_q <= 2'b11;
      press_q    <= 2'b00;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      press_q    <= press_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
  logic             cpu_clk_en_q, cpu_clk_en_d;
  logic             halted_q, halted_d;

  always_comb begin
    state_d = state_q;
    // The hold counter is zero outside HOLD_RESET, so every entry gets the full window.
    hold_d  = '0;
    case (state_q)
      StInit: state_d = StHold;
      StHold: begin
        if (hold_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StRun: begin
        if (press_q[0]) begin
          state_d = StHold;
        end else if (press_q[1]) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (press_q[0]) begin
          state_d = StHold;
        end else if (press_q[1]) begin
          state_d = StStep;
        end
      end
      StStep:  state_d = StHalt;
      default: state_d = StInit;
    endcase

    // Outputs decoded from the next state so they register alongside it.
    cpu_rst_n_d  = (state_d == StRun) || (state_d == StHalt) || (state_d == StStep);
    cpu_clk_en_d = (state_d == StHold) || (state_d == StRun) || (state_d == StStep);
    halted_d     = (state_d == StHalt) || (state_d == StStep);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StInit;
      hold_q       <= '0;
      cpu_rst_n_q  <= 1'b0;
      cpu_clk_en_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      cpu_clk_en_q <= cpu_clk_en_d;
      halted_q     <= halted_d;
    end
  end

  assign cpu_rst_n  = cpu_rst_n_q;
  assign cpu_clk_en = cpu_clk_en_q;
  assign halted     = halted_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DEBOUNCE_CYCLES=8, RESET_HOLD=4.
// Expected output vectors are queued as each stimulus step is driven and are
// popped and compared once per cycle, on the falling clock edge.
module tb_cpu_run_ctrl;

  logic       clk;
  logic       reset;
  logic       btn1;
  logic       btn2;
  logic       cpu_rst_n;
  logic       cpu_clk_en;
  logic       halted;
  logic [2:0] state;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4),
    .RESET_HOLD     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn1      (btn1),
    .btn2      (btn2),
    .cpu_rst_n (cpu_rst_n),
    .cpu_clk_en(cpu_clk_en),
    .halted    (halted),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, cpu_rst_n, cpu_clk_en, halted}
  localparam logic [5:0] VInit = {3'd0, 1'b0, 1'b0, 1'b0};
  localparam logic [5:0] VHold = {3'd1, 1'b0, 1'b1, 1'b0};
  localparam logic [5:0] VRun  = {3'd2, 1'b1, 1'b1, 1'b0};
  localparam logic [5:0] VHalt = {3'd3, 1'b1, 1'b0, 1'b1};
  localparam logic [5:0] VStep = {3'd4, 1'b1, 1'b1, 1'b1};

  typedef struct {
    string       tag;
    int unsigned val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_assert;
  int unsigned n_fail;
  int unsigned en_cnt;
  logic [5:0]  obs;

  assign obs = {state, cpu_rst_n, cpu_clk_en, halted};

  task automatic push_n(input string tag, input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{tag, {26'd0, v}});
  endtask

  task automatic push_val(input string tag, input int unsigned v);
    sb.push_back('{tag, v});
  endtask

  task automatic chk(input int unsigned o);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h required an expectation", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h required %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic chk_out();
    chk({26'd0, obs});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpu_clk_en) en_cnt++;
      chk_out();
    end
  endtask

  // Pulse reset low for one cycle and check the full restart sequence.
  task automatic reset_pulse(input string tag, input int run_after);
    reset = 1'b0;
    #1;
    push_n({tag, "_async"}, VInit, 1);
    chk_out();
    push_n({tag, "_low"}, VInit, 1);
    run(1);
    reset = 1'b1;
    #1;
    push_n({tag, "_init"}, VInit, 1);
    chk_out();
    push_n({tag, "_hold"}, VHold, 4);
    push_n({tag, "_run"}, VRun, run_after);
    run(4 + run_after);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    en_cnt   = 0;
    reset    = 1'b0;
    btn1     = 1'b1;
    btn2     = 1'b1;

    // 1. Reset values, then INIT, 4 cycles of HOLD_RESET, then RUN.
    push_n("reset_vals", VInit, 2);
    run(2);
    reset = 1'b1;
    #1;
    push_n("init", VInit, 1);
    chk_out();
    push_n("por_hold", VHold, 4);
    push_n("por_run", VRun, 4);
    run(8);

    // 2. Short glitch ignored; long press restarts once at edge+11.
    btn1 = 1'b0;
    push_n("glitch_run", VRun, 5);
    run(5);
    btn1 = 1'b1;
    push_n("glitch_after", VRun, 20);
    run(20);
    btn1 = 1'b0;
    push_n("b1_wait", VRun, 11);
    push_n("b1_hold", VHold, 4);
    push_n("b1_run", VRun, 5);
    run(20);
    btn1 = 1'b1;
    push_n("b1_release", VRun, 20);
    run(20);

    // 3. Halt, then three separate presses give three single enable cycles.
    btn2 = 1'b0;
    push_n("halt_wait", VRun, 11);
    push_n("halt", VHalt, 9);
    run(20);
    btn2 = 1'b1;
    push_n("halt_release", VHalt, 20);
    run(20);
    en_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      btn2 = 1'b0;
      push_n("step_wait", VHalt, 11);
      push_n("step", VStep, 1);
      push_n("step_back", VHalt, 8);
      run(20);
      btn2 = 1'b1;
      push_n("step_release", VHalt, 20);
      run(20);
    end
    push_val("step_en_total", 3);
    chk(en_cnt);

    // 4. Both buttons in HALT: restart wins, no STEP.
    btn1 = 1'b0;
    btn2 = 1'b0;
    push_n("both_wait", VHalt, 11);
    push_n("both_hold", VHold, 4);
    push_n("both_run", VRun, 5);
    run(20);
    btn1 = 1'b1;
    btn2 = 1'b1;
    push_n("both_release", VRun, 20);
    run(20);

    // 5a. Reset pulse mid-RUN.
    reset_pulse("rst_run", 6);

    // 5b. Reset pulse mid-STEP; btn2 released while reset is low.
    btn2 = 1'b0;
    push_n("s5_wait", VRun, 11);
    push_n("s5_halt", VHalt, 9);
    run(20);
    btn2 = 1'b1;
    push_n("s5_release", VHalt, 20);
    run(20);
    btn2 = 1'b0;
    push_n("s5_step_wait", VHalt, 11);
    push_n("s5_step", VStep, 1);
    run(12);
    btn2 = 1'b1;
    reset_pulse("rst_step", 16);

    // 6. btn2 held 100 cycles: one HALT, no STEP until release and re-press.
    btn2 = 1'b0;
    push_n("held_wait", VRun, 11);
    push_n("held_halt", VHalt, 89);
    run(100);
    btn2 = 1'b1;
    push_n("held_release", VHalt, 20);
    run(20);
    btn2 = 1'b0;
    push_n("repress_wait", VHalt, 11);
    push_n("repress_step", VStep, 1);
    push_n("repress_back", VHalt, 8);
    run(20);
    btn2 = 1'b1;
    push_n("repress_release", VHalt, 10);
    run(10);

    push_val("sb_drained", 0);
    chk(sb.size() - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
